// File: rtl/ntt_mem_pkg.sv
// ntt_mem_pkg: shared definitions for the NTT coefficient BRAM read streamer.
//   NTT_DW / NTT_AW : default word width and address width (18 x 64 words)
//   rd_state_t      : read-streamer FSM states
//   bitrev_aw       : reverse the low w bits of v. It is only referenced when
//                     the BITREV_EN build option is defined.
package ntt_mem_pkg;

   localparam int NTT_DW = 18;
   localparam int NTT_AW = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   function automatic logic [31:0] bitrev_aw(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

endpackage

// File: rtl/bram_18_6_rd_stream_if.sv
// bram_18_6_rd_stream_if: BRAM read port plus the output valid/ready stream.
//   rd_addr   : streamer -> BRAM read address (registered inside the BRAM)
//   rd_dout   : BRAM -> streamer data, valid one cycle after rd_addr
//   out_valid : stream valid
//   out_ready : stream ready (from the downstream consumer)
//   out_data  : stream data
// The master modport is the streamer. The slave modport is the BRAM and sink side.
interface bram_18_6_rd_stream_if
   import ntt_mem_pkg::*;
#(
   parameter int DW = NTT_DW,
   parameter int AW = NTT_AW
);

   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;

   modport master (
      output rd_addr, out_valid, out_data,
      input  rd_dout, out_ready
   );

   modport slave (
      input  rd_addr, out_valid, out_data,
      output rd_dout, out_ready
   );

endinterface

// File: rtl/skid_fifo_2.sv
// skid_fifo_2: 2-entry synchronous FIFO with a registered head.
//   clk, rst_n : clock and synchronous active-low reset
//   push, din  : write strobe and data (a push is dropped when the FIFO is full and not popping)
//   pop        : read strobe (ignored when the FIFO is empty)
//   count      : occupancy, 0..2
//   head       : oldest entry. It is cleared on reset and holds its last value when the FIFO is empty.
module skid_fifo_2 #(
   parameter int DW = 18
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [1:0]    count,
   output logic [DW-1:0] head
);

   logic [DW-1:0] tail;
   logic          push_ok, pop_ok;

   assign pop_ok  = pop && (count != 2'd0);
   assign push_ok = push && ((count != 2'd2) || pop_ok);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else begin
         count <= count + 2'(push_ok) - 2'(pop_ok);
         if (pop_ok) begin
            // The entry behind the head moves forward. An incoming word fills
            // whichever slot becomes free.
            if (count == 2'd2) begin
               head <= tail;
               if (push_ok) tail <= din;
            end else if (push_ok) begin
               head <= din;
            end
         end else if (push_ok) begin
            if (count == 2'd0) head <= din;
            else               tail <= din;
         end
      end
   end

endmodule

// File: rtl/bram_18_6_rd_stream.sv
// bram_18_6_rd_stream: reads len consecutive BRAM words starting at address 0
// and presents them on a valid/ready stream with full backpressure.
//   clk, rst_n : clock and synchronous active-low reset
//   start, len : start a pass of len words (0 or anything above 2^AW means 2^AW).
//                start is honoured only when idle.
//   bitrev     : (only when BITREV_EN is defined) bit-reversed address order, sampled with start
//   busy       : pass in progress
//   done       : one-cycle pulse after the last word is accepted
//   bus        : BRAM read port plus the output stream (master side)
// Build option: BITREV_EN adds the bitrev input and the bit-reversed addressing.
module bram_18_6_rd_stream
   import ntt_mem_pkg::*;
#(
   parameter int DW = NTT_DW,
   parameter int AW = NTT_AW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW:0]           len,
`ifdef BITREV_EN
   input  logic                  bitrev,
`endif
   output logic                  busy,
   output logic                  done,
   bram_18_6_rd_stream_if.master bus
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   rd_state_t     state, state_nxt;
   logic [AW:0]   cnt, remain;
   logic          inflight, issue, last_issue, pop, done_nxt;
   logic [1:0]    count;
   logic [2:0]    occ;
   logic [AW-1:0] addr_hold, issue_addr;
   logic [DW-1:0] head;

   // Words that will be queued or already queued after this cycle. Issuing
   // only when this is at most 1 keeps the 2-entry FIFO from overflowing and
   // still gives 1 word/cycle while out_ready stays high.
   assign pop        = (count != 2'd0) && bus.out_ready;
   assign occ        = 3'(count) + 3'(inflight) - 3'(pop);
   assign issue      = (state == ISSUE) && (occ <= 3'd1);
   assign last_issue = issue && (cnt == remain - 1'b1);

`ifdef BITREV_EN
   logic brev_q;
   assign issue_addr = brev_q ? AW'(bitrev_aw(32'(cnt[AW-1:0]), AW)) : cnt[AW-1:0];
`else
   assign issue_addr = cnt[AW-1:0];
`endif

   // The BRAM has no read enable. Holding the address between issues just
   // repeats a harmless read.
   assign bus.rd_addr   = issue ? issue_addr : addr_hold;
   assign bus.out_valid = (count != 2'd0);
   assign bus.out_data  = head;
   assign busy          = (state != IDLE);

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nxt = ISSUE;
         ISSUE: if (last_issue) state_nxt = DRAIN;
         // The check looks ahead one cycle, so done lands in the cycle right
         // after the final handshake.
         DRAIN: if (occ == 3'd0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         done      <= 1'b0;
         inflight  <= 1'b0;
         cnt       <= '0;
         remain    <= '0;
         addr_hold <= '0;
`ifdef BITREV_EN
         brev_q    <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         done      <= done_nxt;
         inflight  <= issue;
         addr_hold <= bus.rd_addr;
         if ((state == IDLE) && start) begin
            cnt    <= '0;
            remain <= ((len == '0) || (len > DEPTH)) ? DEPTH : len;
`ifdef BITREV_EN
            brev_q <= bitrev;
`endif
         end else if (issue) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   skid_fifo_2 #(.DW(DW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight),
      .din   (bus.rd_dout),
      .pop   (pop),
      .count (count),
      .head  (head)
   );

endmodule

// File: tb/tb_bram_18_6_rd_stream.sv
// tb_bram_18_6_rd_stream: scoreboard bench for bram_18_6_rd_stream.
// A behavioural BRAM model (word i = i + 0x100) sits behind the read port.
// Expected words are queued when a pass is started and are popped on each
// stream handshake. Inputs are driven on the falling edge and outputs are
// sampled there too. Cycle 0 is the cycle in which start is high.
module tb_bram_18_6_rd_stream;
   localparam int DW = 18;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   len = '0;
   logic          busy, done;
`ifdef BITREV_EN
   logic          bitrev = 1'b0;
`endif
   logic [DW-1:0] mem [0:63];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;

   bram_18_6_rd_stream_if #(.DW(DW), .AW(AW)) bus ();

   bram_18_6_rd_stream #(.DW(DW), .AW(AW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .len    (len),
`ifdef BITREV_EN
      .bitrev (bitrev),
`endif
      .busy   (busy),
      .done   (done),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) bus.rd_dout <= mem[bus.rd_addr];

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.rd_addr); end
      checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full();
      int first_v, last_c, done_c, nrx;
      logic [DW-1:0] e;
      first_v = -1; last_c = -1; done_c = -1; nrx = 0;
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(DW'(i + 'h100));
      bus.out_ready = 1'b1; len = '0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_rise: got %b want 1", busy); end
      checks++; if (bus.rd_addr !== '0) begin errors++; $display("FAIL full_first_addr: got %h want 0", bus.rd_addr); end
      for (int c = 1; c < 100 && done_c < 0; c++) begin
         if (bus.out_valid === 1'b1) begin
            if (first_v < 0) first_v = c;
            nrx++; last_c = c; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL full_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL full_data: got %h want %h", bus.out_data, e); end
            end
         end
         if (done === 1'b1) begin
            done_c = c;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_fall: got %b want 0", busy); end
         end
         @(negedge clk);
      end
      checks++; if (first_v != 3) begin errors++; $display("FAIL full_first_valid: got %0d want 3", first_v); end
      checks++; if (last_c != 66) begin errors++; $display("FAIL full_last_word: got %0d want 66", last_c); end
      checks++; if (done_c != 67) begin errors++; $display("FAIL full_done_cycle: got %0d want 67", done_c); end
      checks++; if (nrx != 64) begin errors++; $display("FAIL full_count: got %0d want 64", nrx); end
   endtask

   task automatic test_backpressure();
      int done_c, last_c, nrx;
      logic prev_stall;
      logic [DW-1:0] prev_data, e;
      done_c = -1; last_c = -1; nrx = 0; prev_stall = 1'b0; prev_data = '0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) exp_q.push_back(DW'(i + 'h100));
      bus.out_ready = 1'($urandom_range(0, 1)); len = 7'd5; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 200 && done_c < 0; c++) begin
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
               errors++; $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h", bus.out_valid, bus.out_data, prev_data);
            end
         end
         if (done === 1'b1) done_c = c;
         bus.out_ready = 1'($urandom_range(0, 1));
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            nrx++; last_c = c; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL bp_data: got %h want %h", bus.out_data, e); end
            end
         end
         prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
         prev_data  = bus.out_data;
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      checks++; if (nrx != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", nrx); end
      checks++; if (done_c != last_c + 1) begin errors++; $display("FAIL bp_done_cycle: got %0d want %0d", done_c, last_c + 1); end
   endtask

   task automatic test_start_busy();
      int nrx, ndone, relaunch_c;
      logic [DW-1:0] e;
      nrx = 0; ndone = 0; relaunch_c = -10;
      exp_q.delete();
      for (int i = 0; i < 3; i++) exp_q.push_back(DW'(i + 'h100));
      for (int i = 0; i < 2; i++) exp_q.push_back(DW'(i + 'h100));
      bus.out_ready = 1'b1; len = 7'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; len = 7'd1;   // busy here, must be ignored
      @(negedge clk); start = 1'b0;
      for (int c = 3; c < 60 && ndone < 2; c++) begin
         if (bus.out_valid === 1'b1) begin
            nrx++; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL sb_data: got %h want %h", bus.out_data, e); end
            end
         end
         if (relaunch_c == c - 1) begin
            start = 1'b0;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_relaunch_busy: got %b want 1", busy); end
         end
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin
               checks++; if (nrx != 3) begin errors++; $display("FAIL sb_first_pass: got %0d want 3", nrx); end
               start = 1'b1; len = 7'd2; relaunch_c = c;
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++; if (ndone != 2) begin errors++; $display("FAIL sb_done_count: got %0d want 2", ndone); end
      checks++; if (nrx != 5) begin errors++; $display("FAIL sb_count: got %0d want 5", nrx); end
   endtask

   task automatic test_reset_mid();
      int nrx, done_c;
      logic saw_done, saw_valid;
      logic [DW-1:0] e;
      nrx = 0; done_c = -1; saw_done = 1'b0; saw_valid = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i + 'h100));
      bus.out_ready = 1'b1; len = 7'd8; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 40 && nrx < 3; c++) begin
         if (bus.out_valid === 1'b1) begin
            nrx++; checks++;
            e = exp_q.pop_front();
            if (bus.out_data !== e) begin errors++; $display("FAIL rm_data: got %h want %h", bus.out_data, e); end
         end
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_cleared: got %b want 0", bus.out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy_cleared: got %b want 0", busy); end
      repeat (10) begin
         if (done === 1'b1) saw_done = 1'b1;
         if (bus.out_valid === 1'b1) saw_valid = 1'b1;
         @(negedge clk);
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rm_no_done: got %b want 0", saw_done); end
      checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rm_no_valid: got %b want 0", saw_valid); end
      exp_q.delete();
      exp_q.push_back(DW'('h100)); exp_q.push_back(DW'('h101));
      nrx = 0; len = 7'd2; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 40 && done_c < 0; c++) begin
         if (bus.out_valid === 1'b1) begin
            nrx++; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rm2_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL rm2_data: got %h want %h", bus.out_data, e); end
            end
         end
         if (done === 1'b1) done_c = c;
         @(negedge clk);
      end
      checks++; if (nrx != 2) begin errors++; $display("FAIL rm2_count: got %0d want 2", nrx); end
      checks++; if (done_c != 5) begin errors++; $display("FAIL rm2_done_cycle: got %0d want 5", done_c); end
   endtask

   task automatic test_len1_stall();
      int done_c, last_c;
      logic [DW-1:0] e;
      done_c = -1; last_c = -1;
      exp_q.delete();
      exp_q.push_back(DW'('h100));
      bus.out_ready = 1'b0; len = 7'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 40 && done_c < 0; c++) begin
         checks++; if (bus.rd_addr !== '0) begin errors++; $display("FAIL l1_addr: got %h want 0 at cycle %0d", bus.rd_addr, c); end
         if (c < 3) begin
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL l1_early_valid: got %b want 0 at cycle %0d", bus.out_valid, c); end
         end else if (c <= 12) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== DW'('h100)) begin
               errors++; $display("FAIL l1_hold: got v=%b d=%h want v=1 d=100 at cycle %0d", bus.out_valid, bus.out_data, c);
            end
         end
         if (done === 1'b1) done_c = c;
         bus.out_ready = (c >= 13);
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            last_c = c; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL l1_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL l1_data: got %h want %h", bus.out_data, e); end
            end
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      checks++; if (last_c != 13) begin errors++; $display("FAIL l1_accept_cycle: got %0d want 13", last_c); end
      checks++; if (done_c != 14) begin errors++; $display("FAIL l1_done_cycle: got %0d want 14", done_c); end
   endtask

   task automatic test_len_sat();
      int done_c, nrx;
      logic [DW-1:0] e;
      done_c = -1; nrx = 0;
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(DW'(i + 'h100));
      bus.out_ready = 1'b1; len = 7'd100; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c < 100 && done_c < 0; c++) begin
         if (bus.out_valid === 1'b1) begin
            nrx++; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sat_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL sat_data: got %h want %h", bus.out_data, e); end
            end
         end
         if (done === 1'b1) done_c = c;
         @(negedge clk);
      end
      checks++; if (nrx != 64) begin errors++; $display("FAIL sat_count: got %0d want 64", nrx); end
      checks++; if (done_c != 67) begin errors++; $display("FAIL sat_done_cycle: got %0d want 67", done_c); end
   endtask

`ifdef BITREV_EN
   task automatic test_bitrev();
      int done_c, nrx;
      logic [5:0] v, r;
      logic [DW-1:0] e;
      done_c = -1; nrx = 0;
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         for (int b = 0; b < 6; b++) r[b] = v[5-b];
         exp_q.push_back(DW'(r) + DW'('h100));
      end
      bus.out_ready = 1'b1; len = '0; bitrev = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0; bitrev = 1'b0;
      for (int c = 1; c < 100 && done_c < 0; c++) begin
         if (bus.out_valid === 1'b1) begin
            nrx++; checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL br_extra: got %h want none", bus.out_data); end
            else begin
               e = exp_q.pop_front();
               if (bus.out_data !== e) begin errors++; $display("FAIL br_data: got %h want %h", bus.out_data, e); end
            end
         end
         if (done === 1'b1) done_c = c;
         @(negedge clk);
      end
      checks++; if (nrx != 64) begin errors++; $display("FAIL br_count: got %0d want 64", nrx); end
      checks++; if (done_c != 67) begin errors++; $display("FAIL br_done_cycle: got %0d want 67", done_c); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = DW'(i + 'h100);
      bus.out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_full();
      test_backpressure();
      test_start_busy();
      test_reset_mid();
      test_len1_stall();
      test_len_sat();
`ifdef BITREV_EN
      test_bitrev();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
